// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

   localparam int WORD_W            = 32;
   localparam int DEFAULT_BASE_ADDR = 1024;

   typedef logic [WORD_W-1:0] word_t;

   // Access sequencer states: IDLE accepts a new request, BUSY burns wait states.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage : mem_stage_pkg

// File: rtl/data_mem.sv
// data_mem: single-port word-addressed data memory, synchronous write,
// asynchronous read.
module data_mem
   import mem_stage_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  word_t         wdata,
   output word_t         rdata
);

   word_t mem [DEPTH];

   // Write port: one word per clock when we is set.
   // NOTE: the storage array has no reset; clearing a RAM would need a
   // per-word reset tree and real memories cannot do it anyway.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule : data_mem

// File: rtl/mem_stage.sv
// mem_stage: memory stage between execute and write-back. Loads and stores
// take WAIT_STATES+1 cycles and hold the upstream pipeline with freeze while
// they wait. Holds the MEM/WB pipeline register.
// Optional build macro MEM_RANGE_CHECK_EN: out-of-window addresses suppress
// stores and read as 0; without it the word index wraps modulo DEPTH.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int WAIT_STATES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_EN,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [WORD_W-1:0] ALU_Res,
   input  logic [WORD_W-1:0] Val_Rm,
   input  logic [3:0]        Dest,
   output logic              freeze,
   output logic              WB_EN_out,
   output logic              MEM_R_EN_out,
   output logic [WORD_W-1:0] ALU_Res_out,
   output logic [WORD_W-1:0] Mem_Data,
   output logic [3:0]        Dest_out
);

   localparam int         AW       = $clog2(DEPTH);
   localparam bit         HAS_WAIT = (WAIT_STATES != 0);
   localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t     state;
   logic [3:0] cnt;

   // Request captured on entry to BUSY; the live inputs are ignored after that.
   word_t      cap_addr;
   word_t      cap_data;
   logic       cap_wb;
   logic       cap_r;
   logic       cap_w;
   logic [3:0] cap_dest;

   // Request actually being served this cycle.
   word_t      req_addr;
   word_t      req_data;
   logic       req_wb;
   logic       req_r;
   logic       req_w;
   logic [3:0] req_dest;

   logic          busy;
   logic          access;
   logic          is_load;
   logic          in_range;
   logic          mem_we;
   logic [AW-1:0] mem_idx;
   word_t         rd_word;
   word_t         load_data;

   assign busy = (state == BUSY);

   // Select between the live inputs and the captured request.
   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so
      // no path can leave one unassigned and infer a latch.
      req_addr = ALU_Res;
      req_data = Val_Rm;
      req_wb   = WB_EN;
      req_r    = MEM_R_EN;
      req_w    = MEM_W_EN;
      req_dest = Dest;
      if (busy) begin
         req_addr = cap_addr;
         req_data = cap_data;
         req_wb   = cap_wb;
         req_r    = cap_r;
         req_w    = cap_w;
         req_dest = cap_dest;
      end
   end

   // A store wins when both request flags are set.
   assign access  = req_r | req_w;
   assign is_load = req_r & ~req_w;

   // Stall while entering a waited access and while wait states remain.
   assign freeze = busy ? (cnt != 4'd0) : (access & HAS_WAIT);

   assign mem_idx = AW'((req_addr - word_t'(BASE_ADDR)) >> 2);

`ifdef MEM_RANGE_CHECK_EN
   // One unsigned compare covers both ends: addresses below the base wrap
   // to huge offsets.
   assign in_range = (req_addr - word_t'(BASE_ADDR)) < word_t'(4 * DEPTH);
`else
   assign in_range = 1'b1;
`endif

   // The write lands only on the completing edge of a store.
   assign mem_we    = req_w & ~freeze & in_range;
   assign load_data = (is_load & in_range) ? rd_word : '0;

   data_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_idx),
      .wdata (req_data),
      .rdata (rd_word)
   );

   // Access sequencer, request capture and MEM/WB register.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         cap_addr     <= '0;
         cap_data     <= '0;
         cap_wb       <= 1'b0;
         cap_r        <= 1'b0;
         cap_w        <= 1'b0;
         cap_dest     <= 4'd0;
         WB_EN_out    <= 1'b0;
         MEM_R_EN_out <= 1'b0;
         ALU_Res_out  <= '0;
         Mem_Data     <= '0;
         Dest_out     <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (access && HAS_WAIT) begin
                  cap_addr <= ALU_Res;
                  cap_data <= Val_Rm;
                  cap_wb   <= WB_EN;
                  cap_r    <= MEM_R_EN;
                  cap_w    <= MEM_W_EN;
                  cap_dest <= Dest;
                  cnt      <= CNT_INIT;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else             state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // A bubble while stalled keeps write-back from firing twice.
         if (freeze) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            ALU_Res_out  <= '0;
            Mem_Data     <= '0;
            Dest_out     <= 4'd0;
         end else begin
            WB_EN_out    <= req_wb;
            MEM_R_EN_out <= is_load;
            ALU_Res_out  <= req_addr;
            Mem_Data     <= load_data;
            Dest_out     <= req_dest;
         end
      end
   end

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// tb_mem_stage: drives two mem_stage instances (3 wait states and 0 wait
// states) with directed and random operations, predicting each result from
// an array model of the data memory.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int DEPTH = 64;
   localparam int BASE  = 1024;
   localparam int WS0   = 3;
   localparam int WS1   = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        wb_en    [2];
   logic        mem_r_en [2];
   logic        mem_w_en [2];
   logic [31:0] alu_res  [2];
   logic [31:0] val_rm   [2];
   logic [3:0]  dest     [2];
   logic        freeze_o [2];
   logic        wb_en_o  [2];
   logic        mem_r_o  [2];
   logic [31:0] alu_o    [2];
   logic [31:0] mdata_o  [2];
   logic [3:0]  dest_o   [2];

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [2][DEPTH];

   mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS0)) u_dut0 (
      .clk(clk), .rst(rst),
      .WB_EN(wb_en[0]), .MEM_R_EN(mem_r_en[0]), .MEM_W_EN(mem_w_en[0]),
      .ALU_Res(alu_res[0]), .Val_Rm(val_rm[0]), .Dest(dest[0]),
      .freeze(freeze_o[0]), .WB_EN_out(wb_en_o[0]), .MEM_R_EN_out(mem_r_o[0]),
      .ALU_Res_out(alu_o[0]), .Mem_Data(mdata_o[0]), .Dest_out(dest_o[0])
   );

   mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) u_dut1 (
      .clk(clk), .rst(rst),
      .WB_EN(wb_en[1]), .MEM_R_EN(mem_r_en[1]), .MEM_W_EN(mem_w_en[1]),
      .ALU_Res(alu_res[1]), .Val_Rm(val_rm[1]), .Dest(dest[1]),
      .freeze(freeze_o[1]), .WB_EN_out(wb_en_o[1]), .MEM_R_EN_out(mem_r_o[1]),
      .ALU_Res_out(alu_o[1]), .Mem_Data(mdata_o[1]), .Dest_out(dest_o[1])
   );

   function automatic int wait_of(input int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   function automatic bit in_range(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE + 4 * DEPTH));
`else
      return 1'b1;
`endif
   endfunction

   function automatic int index_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'(BASE);
      return int'((off / 4) % DEPTH);
   endfunction

   task automatic set_inputs(input int d, input bit wb, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] v, input logic [3:0] ds);
      wb_en[d]    = wb;
      mem_r_en[d] = r;
      mem_w_en[d] = w;
      alu_res[d]  = a;
      val_rm[d]   = v;
      dest[d]     = ds;
   endtask

   task automatic set_idle(input int d);
      set_inputs(d, 1'b0, 1'b0, 1'b0, $urandom(), $urandom(), 4'($urandom()));
   endtask

   // One operation on DUT d; starts before a rising edge, ends at the falling
   // edge after the result lands in MEM/WB.
   task automatic run_op(input int d, input bit wb, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] v, input logic [3:0] ds);
      int          n;
      bit          ld;
      logic [31:0] exp_md;
      ld     = r && !w;
      n      = (r || w) ? wait_of(d) : 0;
      exp_md = 32'd0;
      if (ld && in_range(a)) exp_md = ref_mem[d][index_of(a)];
      @(posedge clk); #1;
      set_inputs(d, wb, r, w, a, v, ds);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (freeze_o[d] !== 1'b1) begin
            errors++;
            $display("FAIL freeze_wait dut%0d cyc%0d: got %b expected 1", d, i, freeze_o[d]);
         end
         if (i > 0) begin
            checks++;
            if ({wb_en_o[d], mem_r_o[d]} !== 2'b00) begin
               errors++;
               $display("FAIL bubble dut%0d cyc%0d: wb/mr got %b%b expected 00", d, i, wb_en_o[d], mem_r_o[d]);
            end
         end
         @(posedge clk); #1;
         set_inputs(d, 1'($urandom()), 1'($urandom()), 1'($urandom()), $urandom(), $urandom(), 4'($urandom()));
      end
      @(negedge clk);
      checks++;
      if (freeze_o[d] !== 1'b0) begin
         errors++;
         $display("FAIL freeze_done dut%0d: got %b expected 0", d, freeze_o[d]);
      end
      @(posedge clk); #1;
      set_idle(d);
      if (w && in_range(a)) ref_mem[d][index_of(a)] = v;
      @(negedge clk);
      checks++;
      if (wb_en_o[d] !== wb) begin
         errors++;
         $display("FAIL wb_en_out dut%0d: got %b expected %b", d, wb_en_o[d], wb);
      end
      checks++;
      if (mem_r_o[d] !== ld) begin
         errors++;
         $display("FAIL mem_r_en_out dut%0d: got %b expected %b", d, mem_r_o[d], ld);
      end
      checks++;
      if (alu_o[d] !== a) begin
         errors++;
         $display("FAIL alu_res_out dut%0d: got %h expected %h", d, alu_o[d], a);
      end
      checks++;
      if (mdata_o[d] !== exp_md) begin
         errors++;
         $display("FAIL mem_data dut%0d addr %0d: got %h expected %h", d, a, mdata_o[d], exp_md);
      end
      checks++;
      if (dest_o[d] !== ds) begin
         errors++;
         $display("FAIL dest_out dut%0d: got %h expected %h", d, dest_o[d], ds);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({freeze_o[d], wb_en_o[d], mem_r_o[d]} !== 3'b000) begin
            errors++;
            $display("FAIL %s flags dut%0d: freeze/wb/mr got %b%b%b expected 000", tag, d, freeze_o[d], wb_en_o[d], mem_r_o[d]);
         end
         checks++;
         if ({alu_o[d], mdata_o[d], dest_o[d]} !== 68'd0) begin
            errors++;
            $display("FAIL %s data dut%0d: alu %h mdata %h dest %h expected all 0", tag, d, alu_o[d], mdata_o[d], dest_o[d]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) set_inputs(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("in_reset");
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("after_reset");
   endtask

   task automatic test_fill();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++)
            run_op(d, 1'b0, 1'b0, 1'b1, 32'(BASE + 4 * i), $urandom(), 4'd0);
   endtask

   task automatic test_store();
      run_op(0, 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0);
      checks++;
      if (u_dut0.u_mem.mem[1] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL store_word1: got %h expected deadbeef", u_dut0.u_mem.mem[1]);
      end
   endtask

   task automatic test_load();
      run_op(0, 1'b1, 1'b1, 1'b0, 32'd1028, $urandom(), 4'd5);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({wb_en_o[0], mem_r_o[0], mdata_o[0]} !== 34'd0) begin
         errors++;
         $display("FAIL load_one_cycle: wb %b mr %b mdata %h expected 0 0 0", wb_en_o[0], mem_r_o[0], mdata_o[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic [3:0]  ds;
      v  = $urandom();
      ds = 4'($urandom());
      @(posedge clk); #1;
      set_inputs(1, 1'b0, 1'b0, 1'b1, 32'd1032, v, 4'd0);
      @(negedge clk);
      checks++;
      if (freeze_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_store_freeze: got %b expected 0", freeze_o[1]);
      end
      @(posedge clk); #1;
      ref_mem[1][2] = v;
      set_inputs(1, 1'b1, 1'b1, 1'b0, 32'd1032, $urandom(), ds);
      @(negedge clk);
      checks++;
      if ({freeze_o[1], mem_r_o[1], mdata_o[1]} !== 34'd0) begin
         errors++;
         $display("FAIL b2b_store_out: freeze %b mr %b mdata %h expected 0 0 0", freeze_o[1], mem_r_o[1], mdata_o[1]);
      end
      @(posedge clk); #1;
      set_idle(1);
      @(negedge clk);
      checks++;
      if ({mem_r_o[1], mdata_o[1], dest_o[1]} !== {1'b1, v, ds}) begin
         errors++;
         $display("FAIL b2b_load_out: mr %b mdata %h dest %h expected 1 %h %h", mem_r_o[1], mdata_o[1], dest_o[1], v, ds);
      end
   endtask

   task automatic test_non_mem();
      run_op(0, 1'b1, 1'b0, 1'b0, 32'h7, $urandom(), 4'd3);
      run_op(1, 1'b1, 1'b0, 1'b0, 32'h7, $urandom(), 4'd9);
   endtask

   task automatic test_reset_mid_access();
      @(posedge clk); #1;
      set_inputs(0, 1'b0, 1'b0, 1'b1, 32'd1036, ~ref_mem[0][3], 4'd0);
      @(posedge clk); #1;
      set_idle(0);
      set_idle(1);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      check_all_zero("mid_reset");
      run_op(0, 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd1);
   endtask

   task automatic test_range();
      int bad;
      logic [31:0] v;
      v = $urandom();
      run_op(0, 1'b0, 1'b0, 1'b1, 32'd1020, v, 4'd0);
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
         if (u_dut0.u_mem.mem[i] !== ref_mem[0][i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL range_store_words: %0d words differ, expected 0", bad);
      end
      run_op(0, 1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd2);
      run_op(0, 1'b1, 1'b1, 1'b0, 32'(BASE + 4 * (DEPTH - 1)), 32'd0, 4'd2);
   endtask

   task automatic test_random();
      int          d;
      int          kind;
      logic [31:0] a;
      for (int k = 0; k < 80; k++) begin
         d    = k % 2;
         kind = $urandom_range(0, 3);
         if (kind == 0)
            a = $urandom();
         else if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 0) ? 32'(BASE - 4 * $urandom_range(1, 8))
                                           : 32'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 8));
         else
            a = 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
         run_op(d, 1'($urandom()), (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                a, $urandom(), 4'($urandom()));
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_store();
      test_load();
      test_back_to_back();
      test_non_mem();
      test_reset_mid_access();
      test_range();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_stage
